// File: rtl/vga_pkg.sv
// Shared definitions for the VGA sink/monitor blocks.
//   - Default expected active geometry (640x480).
//   - Receiver FSM state encoding.
//   - Field positions inside the 24-bit {b, g, r} pixel word.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  localparam int BGR_W = 24;
  localparam int R_LSB = 0;
  localparam int R_MSB = 7;
  localparam int G_LSB = 8;
  localparam int G_MSB = 15;
  localparam int B_LSB = 16;
  localparam int B_MSB = 23;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } vga_state_e;

endpackage

// File: rtl/vga_edge_detect.sv
// Registered falling-edge detector.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   d_i    : level to watch (already synchronous to clk_i)
//   fall_o : high for the cycle in which d_i is 0 after having been 1
module vga_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic fall_o
);

  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= d_i;
    end
  end

  assign fall_o = prev_q & ~d_i;

endmodule

// File: rtl/vga_frame_receiver.sv
// VGA pixel-interface sink used as an in-fabric loopback monitor.
// Recovers pixel coordinates, measures active width/height per frame,
// declares lock against the expected geometry and sums the active pixels.
//   vga_clk    : pixel clock, rising edge
//   reset      : asynchronous active-high reset
//   hs_n/vs_n  : active-low syncs; blank_n high marks an active pixel
//   bgr        : pixel word {b, g, r}
//   pix_*      : pixel, coordinates and valid, two clocks after the sample
//   locked     : last measured frame matched H_ACTIVE x V_ACTIVE
//   frame_done : one-cycle pulse at each measured frame boundary
//   meas_w/h   : width/lines of the last completed frame
//   frame_sum  : mod-2^24 sum of the active pixels of the last frame
module vga_frame_receiver
  import vga_pkg::*;
#(
  parameter int H_ACTIVE      = H_ACTIVE_DEF,
  parameter int V_ACTIVE      = V_ACTIVE_DEF,
  parameter int FRAME_TIMEOUT = 1000000,
  parameter int XW            = 10,
  parameter int YW            = 9
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             hs_n,
  input  logic             vs_n,
  input  logic             blank_n,
  input  logic [BGR_W-1:0] bgr,
  output logic             pix_valid,
  output logic [XW-1:0]    pix_x,
  output logic [YW-1:0]    pix_y,
  output logic [BGR_W-1:0] pix_bgr,
  output logic             locked,
  output logic             frame_done,
  output logic [XW-1:0]    meas_w,
  output logic [YW-1:0]    meas_h,
  output logic [BGR_W-1:0] frame_sum
);

  localparam int TMR_W = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;

  function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
    return (&v) ? v : v + XW'(1);
  endfunction

  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
    return (&v) ? v : v + YW'(1);
  endfunction

  function automatic logic [BGR_W-1:0] wrap_add(input logic [BGR_W-1:0] a,
                                                input logic [BGR_W-1:0] b);
    return a + b;
  endfunction

  logic             hs_p1_q, vs_p1_q, blank_p1_q;
  logic [BGR_W-1:0] bgr_p1_q;
  logic             vs_fall, blank_fall;
  logic             unused_hs;

  vga_state_e       state_q, state_d;
  logic [XW-1:0]    x_q, x_d, first_w_q, first_w_d;
  logic [YW-1:0]    y_q, y_d;
  logic             have_w_q, have_w_d, mism_q, mism_d;
  logic [BGR_W-1:0] sum_q, sum_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             check_ok;

  logic             vld_p2_q, vld_p2_d;
  logic [XW-1:0]    x_p2_q, x_p2_d;
  logic [YW-1:0]    y_p2_q, y_p2_d;
  logic [BGR_W-1:0] bgr_p2_q, bgr_p2_d;
  logic             locked_q, locked_d, done_q, done_d;
  logic [XW-1:0]    meas_w_q, meas_w_d;
  logic [YW-1:0]    meas_h_q, meas_h_d;
  logic [BGR_W-1:0] fsum_q, fsum_d;

  // Horizontal sync is registered with the other inputs for alignment, but
  // line structure is recovered from blank_n alone.
  assign unused_hs = hs_p1_q;

  // ---- stage 1: input sampling ----
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_p1_q    <= 1'b0;
      vs_p1_q    <= 1'b0;
      blank_p1_q <= 1'b0;
    end else begin
      hs_p1_q    <= hs_n;
      vs_p1_q    <= vs_n;
      blank_p1_q <= blank_n;
    end
  end

  always_ff @(posedge vga_clk) begin
    bgr_p1_q <= bgr;
  end

  vga_edge_detect u_vs_edge (
    .clk_i  (vga_clk),
    .rst_i  (reset),
    .d_i    (vs_p1_q),
    .fall_o (vs_fall)
  );

  vga_edge_detect u_blank_edge (
    .clk_i  (vga_clk),
    .rst_i  (reset),
    .d_i    (blank_p1_q),
    .fall_o (blank_fall)
  );

  // ---- stage 2: counting, FSM and output registers ----
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    first_w_d = first_w_q;
    have_w_d  = have_w_q;
    mism_d    = mism_q;
    sum_d     = sum_q;
    tmr_d     = tmr_q;
    x_p2_d    = x_q;
    y_p2_d    = y_q;
    bgr_p2_d  = {bgr_p1_q[B_MSB:B_LSB], bgr_p1_q[G_MSB:G_LSB], bgr_p1_q[R_MSB:R_LSB]};
    locked_d  = locked_q;
    done_d    = 1'b0;
    meas_w_d  = meas_w_q;
    meas_h_d  = meas_h_q;
    fsum_d    = fsum_q;
    check_ok  = (first_w_q == XW'(H_ACTIVE)) && (y_q == YW'(V_ACTIVE)) && !mism_q;

    // A frame start wins over everything else in the same cycle: a pixel
    // arriving with it is the first pixel (0,0) of the new frame.
    if (vs_fall) begin
      x_d       = blank_p1_q ? XW'(1) : '0;
      y_d       = '0;
      first_w_d = '0;
      have_w_d  = 1'b0;
      mism_d    = 1'b0;
      sum_d     = blank_p1_q ? bgr_p1_q : '0;
      x_p2_d    = '0;
      y_p2_d    = '0;
    end else begin
      if (blank_p1_q) begin
        x_d   = sat_inc_x(x_q);
        sum_d = wrap_add(sum_q, bgr_p1_q);
        if (&x_q) mism_d = 1'b1;
      end
      // blank_fall implies blank_p1_q is low, so x_q holds the finished run.
      if (blank_fall) begin
        x_d = '0;
        if (x_q != '0) begin
          y_d = sat_inc_y(y_q);
          if (&y_q) mism_d = 1'b1;
          if (!have_w_q) begin
            first_w_d = x_q;
            have_w_d  = 1'b1;
          end else if (x_q != first_w_q) begin
            mism_d = 1'b1;
          end
        end
      end
    end

    case (state_q)
      SEARCH: begin
        tmr_d = '0;
        if (vs_fall) state_d = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (vs_fall) begin
          tmr_d    = '0;
          done_d   = 1'b1;
          meas_w_d = first_w_q;
          meas_h_d = y_q;
          fsum_d   = sum_q;
          if (check_ok) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end else if (state_q == LOCKED) begin
            state_d  = SEARCH;
            locked_d = 1'b0;
          end
        end else if (tmr_q == TMR_W'(FRAME_TIMEOUT - 1)) begin
          // Watchdog: the source stopped producing frames.
          state_d  = SEARCH;
          locked_d = 1'b0;
          tmr_d    = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = SEARCH;
    endcase

    vld_p2_d = blank_p1_q && (state_d != SEARCH);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      x_q       <= '0;
      y_q       <= '0;
      first_w_q <= '0;
      have_w_q  <= 1'b0;
      mism_q    <= 1'b0;
      sum_q     <= '0;
      tmr_q     <= '0;
      vld_p2_q  <= 1'b0;
      x_p2_q    <= '0;
      y_p2_q    <= '0;
      bgr_p2_q  <= '0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
      meas_w_q  <= '0;
      meas_h_q  <= '0;
      fsum_q    <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      first_w_q <= first_w_d;
      have_w_q  <= have_w_d;
      mism_q    <= mism_d;
      sum_q     <= sum_d;
      tmr_q     <= tmr_d;
      vld_p2_q  <= vld_p2_d;
      x_p2_q    <= x_p2_d;
      y_p2_q    <= y_p2_d;
      bgr_p2_q  <= bgr_p2_d;
      locked_q  <= locked_d;
      done_q    <= done_d;
      meas_w_q  <= meas_w_d;
      meas_h_q  <= meas_h_d;
      fsum_q    <= fsum_d;
    end
  end

  assign pix_valid  = vld_p2_q;
  assign pix_x      = x_p2_q;
  assign pix_y      = y_p2_q;
  assign pix_bgr    = bgr_p2_q;
  assign locked     = locked_q;
  assign frame_done = done_q;
  assign meas_w     = meas_w_q;
  assign meas_h     = meas_h_q;
  assign frame_sum  = fsum_q;

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Directed bench for vga_frame_receiver on a reduced 8x4 active geometry
// (12 clocks per line, 7 lines per frame, vsync low on line 5).
module tb_vga_frame_receiver;

  localparam int H_ACT   = 8;
  localparam int V_ACT   = 4;
  localparam int TMO     = 300;
  localparam int XW      = 10;
  localparam int YW      = 9;
  localparam int H_TOT   = 12;
  localparam int V_TOT   = 7;
  localparam int VS_LINE = 5;

  typedef struct packed {
    logic          en;
    logic          vld;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [23:0]   d;
  } tag_t;

  logic          vga_clk = 1'b0;
  logic          reset, hs_n, vs_n, blank_n;
  logic [23:0]   bgr;
  logic          pix_valid, locked, frame_done;
  logic [XW-1:0] pix_x, meas_w;
  logic [YW-1:0] pix_y, meas_h;
  logic [23:0]   pix_bgr, frame_sum;

  int            n_chk = 0;
  int            n_err = 0;
  int            fd_cnt = 0;
  logic [XW-1:0] fd_w;
  logic [YW-1:0] fd_h;
  logic [23:0]   fd_sum;
  logic          fd_lock;
  tag_t          hist0, hist1;

  always #5 vga_clk = ~vga_clk;

  vga_frame_receiver #(
    .H_ACTIVE      (H_ACT),
    .V_ACTIVE      (V_ACT),
    .FRAME_TIMEOUT (TMO),
    .XW            (XW),
    .YW            (YW)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .hs_n       (hs_n),
    .vs_n       (vs_n),
    .blank_n    (blank_n),
    .bgr        (bgr),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_bgr    (pix_bgr),
    .locked     (locked),
    .frame_done (frame_done),
    .meas_w     (meas_w),
    .meas_h     (meas_h),
    .frame_sum  (frame_sum)
  );

  // Capture everything that accompanies each frame_done pulse.
  always @(negedge vga_clk) begin
    if (frame_done === 1'b1) begin
      fd_cnt  <= fd_cnt + 1;
      fd_w    <= meas_w;
      fd_h    <= meas_h;
      fd_sum  <= frame_sum;
      fd_lock <= locked;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One input sample per clock. Outputs seen at this negedge belong to the
  // sample driven two calls earlier (hist1).
  task automatic step(input logic v, input logic h, input logic b,
                      input logic [23:0] d, input tag_t t);
    @(negedge vga_clk);
    if (hist1.en) begin
      check_eq("pix_valid", 32'(pix_valid), 32'(hist1.vld));
      if (hist1.vld) begin
        check_eq("pix_x", 32'(pix_x), 32'(hist1.x));
        check_eq("pix_y", 32'(pix_y), 32'(hist1.y));
        check_eq("pix_bgr", 32'(pix_bgr), 32'(hist1.d));
      end
    end
    hist1   = hist0;
    hist0   = t;
    vs_n    = v;
    hs_n    = h;
    blank_n = b;
    bgr     = d;
  endtask

  task automatic run_frame(input logic [23:0] pix, input int short_line, input bit novs,
                           input bit coinc, input bit chk_pix, input bit exp_vld,
                           input int rst_at);
    int idx;
    idx = 0;
    for (int l = 0; l < V_TOT; l++) begin
      for (int c = 0; c < H_TOT; c++) begin
        logic        v, b;
        logic [23:0] d;
        tag_t        t;
        int          w;
        w = (l == short_line) ? H_ACT - 1 : H_ACT;
        v = (l != VS_LINE) || novs;
        b = (l < V_ACT) && (c < w);
        d = b ? pix : 24'h0;
        t = '0;
        if (b && chk_pix) begin
          t.en = 1'b1; t.vld = exp_vld; t.x = XW'(c); t.y = YW'(l); t.d = pix;
        end
        if (coinc && l == VS_LINE && c == 0) begin
          b = 1'b1; d = 24'h123456;
          t.en = 1'b1; t.vld = 1'b1; t.x = '0; t.y = '0; t.d = 24'h123456;
        end
        step(v, !(c >= 9 && c < 11), b, d, t);
        if (idx == rst_at) begin
          check_eq("pre_reset_locked", 32'(locked), 32'd1);
          reset = 1'b1;
          #1;
          check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
          check_eq("rst_pix_x", 32'(pix_x), 32'd0);
          check_eq("rst_pix_y", 32'(pix_y), 32'd0);
          check_eq("rst_pix_bgr", 32'(pix_bgr), 32'd0);
          check_eq("rst_locked", 32'(locked), 32'd0);
          check_eq("rst_meas_w", 32'(meas_w), 32'd0);
          check_eq("rst_meas_h", 32'(meas_h), 32'd0);
          check_eq("rst_frame_sum", 32'(frame_sum), 32'd0);
          hist0 = '0;
          hist1 = '0;
        end
        if (idx == rst_at + 2) reset = 1'b0;
        idx++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; vs_n = 1'b1; hs_n = 1'b1; blank_n = 1'b0; bgr = 24'h0;
    hist0 = '0; hist1 = '0;
    repeat (3) @(negedge vga_clk);
    check_eq("init_pix_valid", 32'(pix_valid), 32'd0);
    check_eq("init_pix_x", 32'(pix_x), 32'd0);
    check_eq("init_pix_y", 32'(pix_y), 32'd0);
    check_eq("init_pix_bgr", 32'(pix_bgr), 32'd0);
    check_eq("init_locked", 32'(locked), 32'd0);
    check_eq("init_frame_done", 32'(frame_done), 32'd0);
    check_eq("init_meas_w", 32'(meas_w), 32'd0);
    check_eq("init_meas_h", 32'(meas_h), 32'd0);
    check_eq("init_frame_sum", 32'(frame_sum), 32'd0);
    reset = 1'b0;

    // Acquire: first frame only starts measurement, second one locks.
    run_frame(24'h000001, -1, 0, 0, 0, 0, -1);
    check_eq("acq_fd_cnt0", 32'(fd_cnt), 32'd0);
    check_eq("acq_locked0", 32'(locked), 32'd0);
    run_frame(24'h000001, -1, 0, 0, 1, 1, -1);
    check_eq("acq_fd_cnt1", 32'(fd_cnt), 32'd1);
    check_eq("acq_fd_lock", 32'(fd_lock), 32'd1);
    check_eq("acq_meas_w", 32'(fd_w), 32'd8);
    check_eq("acq_meas_h", 32'(fd_h), 32'd4);
    check_eq("acq_sum", 32'(fd_sum), 32'h000020);

    // Sum wraps modulo 2^24: 32 * 0x7FFFFF.
    run_frame(24'h7FFFFF, -1, 0, 0, 1, 1, -1);
    check_eq("wrap_fd_cnt", 32'(fd_cnt), 32'd2);
    check_eq("wrap_sum", 32'(fd_sum), 32'hFFFFE0);
    check_eq("wrap_sum_hold", 32'(frame_sum), 32'hFFFFE0);
    check_eq("wrap_meas_w_hold", 32'(meas_w), 32'd8);
    check_eq("wrap_locked", 32'(locked), 32'd1);

    // One short line: lock drops with the same frame_done.
    run_frame(24'h000001, 2, 0, 0, 1, 1, -1);
    check_eq("short_fd_cnt", 32'(fd_cnt), 32'd3);
    check_eq("short_fd_lock", 32'(fd_lock), 32'd0);
    check_eq("short_meas_w", 32'(fd_w), 32'd8);
    check_eq("short_meas_h", 32'(fd_h), 32'd4);
    check_eq("short_sum", 32'(fd_sum), 32'h00001F);
    run_frame(24'h000001, -1, 0, 0, 1, 0, -1);
    check_eq("search_fd_cnt", 32'(fd_cnt), 32'd3);
    run_frame(24'h000001, -1, 0, 0, 1, 1, -1);
    check_eq("relock_fd_cnt", 32'(fd_cnt), 32'd4);
    check_eq("relock_fd_lock", 32'(fd_lock), 32'd1);

    // Watchdog: vsync stops.
    repeat (3) run_frame(24'h000001, -1, 1, 0, 0, 0, -1);
    check_eq("tmo_before_locked", 32'(locked), 32'd1);
    repeat (2) run_frame(24'h000001, -1, 1, 0, 0, 0, -1);
    check_eq("tmo_after_locked", 32'(locked), 32'd0);
    check_eq("tmo_fd_cnt", 32'(fd_cnt), 32'd4);
    run_frame(24'h000001, -1, 1, 0, 1, 0, -1);
    check_eq("tmo_fd_cnt2", 32'(fd_cnt), 32'd4);
    run_frame(24'h000001, -1, 0, 0, 0, 0, -1);
    run_frame(24'h000001, -1, 0, 0, 1, 1, -1);
    check_eq("tmo_relock_fd_cnt", 32'(fd_cnt), 32'd5);
    check_eq("tmo_relock", 32'(locked), 32'd1);

    // Reset mid-line (line 1, column 4) while locked.
    run_frame(24'h000001, -1, 0, 0, 0, 0, 16);
    check_eq("postrst_fd_cnt", 32'(fd_cnt), 32'd5);
    check_eq("postrst_locked", 32'(locked), 32'd0);
    run_frame(24'h000001, -1, 0, 0, 1, 1, -1);
    check_eq("postrst_fd_cnt2", 32'(fd_cnt), 32'd6);
    check_eq("postrst_fd_lock", 32'(fd_lock), 32'd1);
    check_eq("postrst_meas_w", 32'(fd_w), 32'd8);

    // Frame start coincident with an active pixel.
    run_frame(24'h000001, -1, 0, 1, 1, 1, -1);
    check_eq("coinc_fd_cnt", 32'(fd_cnt), 32'd7);
    check_eq("coinc_fd_lock", 32'(fd_lock), 32'd1);
    run_frame(24'h000001, -1, 0, 0, 0, 0, -1);
    check_eq("coinc_fd_cnt2", 32'(fd_cnt), 32'd8);
    check_eq("coinc_sum", 32'(fd_sum), 32'h123476);
    check_eq("coinc_meas_w", 32'(fd_w), 32'd1);
    check_eq("coinc_meas_h", 32'(fd_h), 32'd5);
    check_eq("coinc_fd_lock2", 32'(fd_lock), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
